// File: rtl/lu_op_pkg.sv
// Shared types and helpers for the logic-unit op decoder.
// Op codes follow the logic unit select {keyb,key}.
package lu_op_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_NAND = 2'b10,
    OP_NOR  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    DONE    = 2'b10
  } state_t;

  localparam logic [3:0] CAND_ALL = 4'b1111;

  function automatic logic lu_eval(op_t op, logic a, logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] cand_count(logic [3:0] m);
    return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
  endfunction

  // Lowest set bit wins; only meaningful when exactly one bit is set.
  function automatic logic [1:0] low_index(logic [3:0] m);
    logic [1:0] idx;
    idx = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/lu_op_match.sv
// Combinational consistency check: bit i set when every lane of (a,b,s)
// agrees with op code i.
module lu_op_match
  import lu_op_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_s,
  output logic [3:0]       o_mask
);

  always_comb begin
    o_mask = CAND_ALL;
    for (int op = 0; op < 4; op++) begin
      for (int l = 0; l < WIDTH; l++) begin
        if (i_s[l] != lu_eval(op_t'(op[1:0]), i_a[l], i_b[l])) o_mask[op] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lu_op_decoder.sv
// Recovers the op code of a logic unit by narrowing a candidate mask from observed samples.
// Define LU_OP_AUTORESTART_EN to re-enter COLLECT automatically one cycle after DONE.
module lu_op_decoder
  import lu_op_pkg::*;
#(
  parameter  int WIDTH       = 1,
  parameter  int MAX_SAMPLES = 8,
  localparam int CNT_W       = $clog2(MAX_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_s,
  output logic             o_done,
  output logic [1:0]       o_op,
  output logic             o_unique,
  output logic             o_none,
  output logic [3:0]       o_cand,
  output logic [CNT_W-1:0] o_sample_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SAMPLES);

  state_t           r_state;
  logic             r_ready;
  logic             r_done;
  logic [1:0]       r_op;
  logic             r_unique;
  logic             r_none;
  logic [3:0]       r_mask;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]       w_match;
  logic [3:0]       w_next_mask;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_xfer;
  logic             w_decide;
  logic             w_next_unique;

  lu_op_match #(.WIDTH(WIDTH)) u_match (
    .i_a    (i_a),
    .i_b    (i_b),
    .i_s    (i_s),
    .o_mask (w_match)
  );

  assign w_xfer        = i_in_valid & r_ready;
  assign w_next_mask   = r_mask & w_match;
  assign w_next_cnt    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_next_unique = (cand_count(w_next_mask) == 3'd1);
  assign w_decide      = (cand_count(w_next_mask) <= 3'd1) || (w_next_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_op     <= 2'b00;
      r_unique <= 1'b0;
      r_none   <= 1'b0;
      r_mask   <= CAND_ALL;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= COLLECT;
            r_ready <= 1'b1;
            r_mask  <= CAND_ALL;
            r_cnt   <= '0;
          end
        end
        COLLECT: begin
          // A restart takes priority and discards any sample offered in the same cycle.
          if (i_start) begin
            r_mask <= CAND_ALL;
            r_cnt  <= '0;
          end else if (w_xfer) begin
            r_mask <= w_next_mask;
            r_cnt  <= w_next_cnt;
            if (w_decide) begin
              r_state  <= DONE;
              r_ready  <= 1'b0;
              r_done   <= 1'b1;
              r_unique <= w_next_unique;
              r_none   <= (w_next_mask == 4'b0000);
              r_op     <= w_next_unique ? low_index(w_next_mask) : 2'b00;
            end
          end
        end
        DONE: begin
`ifdef LU_OP_AUTORESTART_EN
          r_state <= COLLECT;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
          r_mask  <= CAND_ALL;
          r_cnt   <= '0;
`else
          if (i_start) begin
            r_state  <= COLLECT;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_op     <= 2'b00;
            r_unique <= 1'b0;
            r_none   <= 1'b0;
            r_mask   <= CAND_ALL;
            r_cnt    <= '0;
          end
`endif
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LU_OP_AUTORESTART_EN
  // The working mask is wiped on auto-restart, so the published mask is kept separately.
  logic [3:0] r_res_cand;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_cand <= CAND_ALL;
    end else if (r_state == COLLECT && !i_start && w_xfer && w_decide) begin
      r_res_cand <= w_next_mask;
    end
  end

  assign o_cand = r_res_cand;
`else
  assign o_cand = r_mask;
`endif

  assign o_in_ready   = r_ready;
  assign o_done       = r_done;
  assign o_op         = r_op;
  assign o_unique     = r_unique;
  assign o_none       = r_none;
  assign o_sample_cnt = r_cnt;

endmodule

// File: tb/tb_lu_op_decoder.sv
// Randomized and directed bench for lu_op_decoder against a transaction-level model.
// Honours LU_OP_AUTORESTART_EN when the whole bundle is built with it.
module tb_lu_op_decoder;

  localparam int W    = 4;
  localparam int MAXS = 4;
  localparam int CW   = $clog2(MAXS + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          inValid = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  s = '0;
  logic          inReady;
  logic          done;
  logic [1:0]    op;
  logic          uniq;
  logic          none;
  logic [3:0]    cand;
  logic [CW-1:0] sampleCnt;

  int checks = 0;
  int errors = 0;

  logic [3:0] mMask;
  int         mCnt;

  lu_op_decoder #(.WIDTH(W), .MAX_SAMPLES(MAXS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_in_valid   (inValid),
    .o_in_ready   (inReady),
    .i_a          (a),
    .i_b          (b),
    .i_s          (s),
    .o_done       (done),
    .o_op         (op),
    .o_unique     (uniq),
    .o_none       (none),
    .o_cand       (cand),
    .o_sample_cnt (sampleCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Unit output for op code k over whole lane vectors.
  function automatic logic [W-1:0] opOut(int k, logic [W-1:0] va, logic [W-1:0] vb);
    case (k)
      0:       return va & vb;
      1:       return va | vb;
      2:       return ~(va & vb);
      default: return ~(va | vb);
    endcase
  endfunction

  function automatic logic [3:0] modelMatch(logic [W-1:0] va, logic [W-1:0] vb, logic [W-1:0] vs);
    logic [3:0] m;
    for (int k = 0; k < 4; k++) m[k] = (opOut(k, va, vb) == vs);
    return m;
  endfunction

  function automatic int countOnes(logic [3:0] m);
    int c = 0;
    for (int k = 0; k < 4; k++) if (m[k]) c++;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doStart();
    start = 1'b1;
    step();
    start = 1'b0;
    mMask = 4'b1111;
    mCnt  = 0;
    checkOutput("start_ready", inReady, 1);
    checkOutput("start_done", done, 0);
    checkOutput("start_cnt", sampleCnt, 0);
`ifndef LU_OP_AUTORESTART_EN
    checkOutput("start_cand", cand, 4'b1111);
`endif
  endtask

  // Offer one sample for one cycle; decided tells whether the model expects DONE next.
  task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic [W-1:0] vs, input bit valid, output bit decided);
    checkOutput("collect_ready", inReady, 1);
    checkOutput("collect_done", done, 0);
    a = va;
    b = vb;
    s = vs;
    inValid = valid;
    step();
    inValid = 1'b0;
    decided = 1'b0;
    if (valid) begin
      mMask = mMask & modelMatch(va, vb, vs);
      mCnt++;
      decided = (countOnes(mMask) <= 1) || (mCnt == MAXS);
    end
    if (!decided) begin
      checkOutput("collect_cnt", sampleCnt, mCnt);
`ifndef LU_OP_AUTORESTART_EN
      checkOutput("collect_cand", cand, mMask);
`endif
    end
  endtask

  task automatic checkResult();
    int idx;
    bit expU;
    expU = (countOnes(mMask) == 1);
    idx = 0;
    for (int k = 3; k >= 0; k--) if (mMask[k]) idx = k;
    checkOutput("res_done", done, 1);
    checkOutput("res_ready", inReady, 0);
    checkOutput("res_cand", cand, mMask);
    checkOutput("res_unique", uniq, expU);
    checkOutput("res_none", none, mMask == 4'b0000);
    checkOutput("res_op", op, expU ? idx : 0);
    checkOutput("res_cnt", sampleCnt, mCnt);
    step();
`ifdef LU_OP_AUTORESTART_EN
    checkOutput("auto_done_pulse", done, 0);
    checkOutput("auto_ready", inReady, 1);
    checkOutput("auto_cnt", sampleCnt, 0);
    checkOutput("auto_cand_held", cand, mMask);
    checkOutput("auto_unique_held", uniq, expU);
`else
    checkOutput("hold_done", done, 1);
    checkOutput("hold_ready", inReady, 0);
    checkOutput("hold_cand", cand, mMask);
`endif
  endtask

  initial begin
    bit d;
    logic [W-1:0] ra, rb, rs;
    int hidden;

    mMask = 4'b1111;
    mCnt  = 0;
    step();
    step();
    checkOutput("rst_ready", inReady, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cand", cand, 4'b1111);
    checkOutput("rst_cnt", sampleCnt, 0);
    checkOutput("rst_op", op, 0);
    checkOutput("rst_unique", uniq, 0);
    checkOutput("rst_none", none, 0);
    rst_n = 1'b1;
    step();

    // start with in_valid in IDLE: sample must not be accepted
    start = 1'b1;
    inValid = 1'b1;
    a = 4'b0000; b = 4'b1111; s = 4'b1111;
    step();
    start = 1'b0;
    inValid = 1'b0;
    checkOutput("idle_start_cnt", sampleCnt, 0);
    checkOutput("idle_start_cand", cand, 4'b1111);
    checkOutput("idle_start_ready", inReady, 1);
    mMask = 4'b1111;
    mCnt  = 0;

    // OR identified from (0,1,1),(1,1,1)
    applyStimulus(4'b0000, 4'b1111, 4'b1111, 1'b1, d);
    applyStimulus(4'b1111, 4'b1111, 4'b1111, 1'b1, d);
    checkOutput("t1_cand", cand, 4'b0010);
    checkOutput("t1_op", op, 2'b01);
    checkOutput("t1_cnt", sampleCnt, 2);
    checkResult();

    // NOR from (0,0,1),(1,0,0)
    doStart();
    applyStimulus(4'b0000, 4'b0000, 4'b1111, 1'b1, d);
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b1, d);
    checkOutput("t2_cand", cand, 4'b1000);
    checkOutput("t2_op", op, 2'b11);
    checkResult();

    // contradiction
    doStart();
    applyStimulus(4'b1111, 4'b1111, 4'b1111, 1'b1, d);
    applyStimulus(4'b0000, 4'b0000, 4'b1111, 1'b1, d);
    checkOutput("t3_none", none, 1);
    checkOutput("t3_cand", cand, 4'b0000);
    checkResult();

    // timeout with AND/NOR still ambiguous
    doStart();
    for (int i = 0; i < MAXS; i++) applyStimulus(4'b0000, 4'b1111, 4'b0000, 1'b1, d);
    checkOutput("t4_cand", cand, 4'b1001);
    checkOutput("t4_unique", uniq, 0);
    checkOutput("t4_cnt", sampleCnt, MAXS);
    checkResult();

    // mixed lanes decide AND in a single sample
    doStart();
    applyStimulus(4'b0011, 4'b0101, 4'b0001, 1'b1, d);
    checkOutput("t6_cand", cand, 4'b0001);
    checkOutput("t6_op", op, 2'b00);
    checkResult();

    // reset mid-COLLECT loses the partial mask
    doStart();
    applyStimulus(4'b0000, 4'b1111, 4'b1111, 1'b1, d);
    rst_n = 1'b0;
    step();
    checkOutput("midrst_ready", inReady, 0);
    checkOutput("midrst_cand", cand, 4'b1111);
    checkOutput("midrst_cnt", sampleCnt, 0);
    checkOutput("midrst_done", done, 0);
    rst_n = 1'b1;
    step();

    // start during COLLECT discards the concurrent transfer
    doStart();
    applyStimulus(4'b0000, 4'b1111, 4'b1111, 1'b1, d);
    start = 1'b1;
    inValid = 1'b1;
    a = 4'b1111; b = 4'b1111; s = 4'b0000;
    step();
    start = 1'b0;
    inValid = 1'b0;
    mMask = 4'b1111;
    mCnt  = 0;
    checkOutput("restart_cnt", sampleCnt, 0);
    checkOutput("restart_ready", inReady, 1);
`ifndef LU_OP_AUTORESTART_EN
    checkOutput("restart_cand", cand, 4'b1111);
`endif

    // randomized trials against the model
    for (int t = 0; t < 40; t++) begin
      doStart();
      hidden = $urandom_range(0, 3);
      d = 1'b0;
      for (int c = 0; c < 40 && !d; c++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        rs = opOut(hidden, ra, rb);
        if ($urandom_range(0, 5) == 0) rs = W'($urandom);
        applyStimulus(ra, rb, rs, $urandom_range(0, 3) != 0, d);
      end
      if (!d) checkOutput("decide_bound", done, 1);
      else    checkResult();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
